// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-requester arbiter for a single-cycle data memory with range checking.
// Define DMEM_ARB_RR_EN for round-robin arbitration; default is fixed priority (m0) with m1 starvation guard.
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif
module dmem_arbiter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        m0_req,
  input  logic        m0_rw,
  input  logic [31:0] m0_addr,
  input  logic [1:0]  m0_size,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_rw,
  input  logic [31:0] m1_addr,
  input  logic [1:0]  m1_size,
  input  logic [31:0] m1_wdata,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_read_write,
  output logic [31:0] mem_address,
  output logic [1:0]  mem_access_size,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out
);
  localparam logic [32:0] START_ADDR = 33'h0_0100_0000;
  localparam logic [32:0] END_ADDR = START_ADDR + 33'(`MEM_DEPTH) - 33'd1;
  logic        ready, sel, gnt_any, legal;
  logic        s_rw;
  logic [31:0] s_addr, s_wdata, addr_q;
  logic [1:0]  s_size;
  logic [32:0] last_byte;
  logic        resp_valid, resp_owner, resp_err;
`ifdef DMEM_ARB_RR_EN
  logic last_m1;
  assign sel = m1_req & (~m0_req | ~last_m1);
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) last_m1 <= 1'b1;
    else if (gnt_any) last_m1 <= sel;
`else
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  assign sel = m1_req & (~m0_req | (starve == CW'(STARVE_LIMIT)));
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) starve <= '0;
    else if (!m1_req || m1_gnt) starve <= '0;
    else if (m0_gnt) starve <= starve + CW'(1);
`endif
  // ready holds off grants until the first clock edge after reset release
  assign m0_gnt = ready & m0_req & ~sel;
  assign m1_gnt = ready & sel;
  assign gnt_any = m0_gnt | m1_gnt;
  assign s_rw = sel ? m1_rw : m0_rw;
  assign s_addr = sel ? m1_addr : m0_addr;
  assign s_size = sel ? m1_size : m0_size;
  assign s_wdata = sel ? m1_wdata : m0_wdata;
  assign last_byte = {1'b0, s_addr} + ((33'd1 << s_size) - 33'd1);
  assign legal = (s_size != 2'd3) && ({1'b0, s_addr} >= START_ADDR) && (last_byte <= END_ADDR);
  assign mem_read_write = gnt_any & s_rw & legal;
  assign mem_address = gnt_any ? s_addr : addr_q;
  assign mem_access_size = s_size;
  assign mem_data_in = s_wdata;
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      ready <= 1'b0;
      resp_valid <= 1'b0;
      resp_owner <= 1'b0;
      resp_err <= 1'b0;
      addr_q <= '0;
    end else begin
      ready <= 1'b1;
      resp_valid <= gnt_any & (~s_rw | ~legal);
      resp_owner <= sel;
      resp_err <= ~legal;
      if (gnt_any) addr_q <= s_addr;
    end
  assign m0_rvalid = resp_valid & ~resp_owner;
  assign m1_rvalid = resp_valid & resp_owner;
  assign m0_err = m0_rvalid & resp_err;
  assign m1_err = m1_rvalid & resp_err;
  assign m0_rdata = (m0_rvalid & ~resp_err) ? mem_data_out : '0;
  assign m1_rdata = (m1_rvalid & ~resp_err) ? mem_data_out : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter with a byte-addressed memory model.
`ifndef MEM_DEPTH
`define MEM_DEPTH 1024
`endif
module tb_dmem_arbiter;
  localparam int D = `MEM_DEPTH;
  localparam logic [31:0] START = 32'h0100_0000;
  logic clock = 1'b0, reset_n;
  logic m0_req, m0_rw, m1_req, m1_rw;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [1:0] m0_size, m1_size;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic mem_read_write;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic [1:0] mem_access_size;
  logic [7:0] mem [D];
  int n_cmp = 0, n_err = 0;
  logic e0;
  logic [31:0] bexp;

  dmem_arbiter #(.STARVE_LIMIT(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .m0_req(m0_req), .m0_rw(m0_rw), .m0_addr(m0_addr), .m0_size(m0_size), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_rw(m1_rw), .m1_addr(m1_addr), .m1_size(m1_size), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_read_write(mem_read_write), .mem_address(mem_address), .mem_access_size(mem_access_size),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] rd_word(input logic [31:0] a);
    int unsigned b;
    b = ((a - START) & ~32'd3) % D;
    return {mem[(b + 3) % D], mem[(b + 2) % D], mem[(b + 1) % D], mem[b]};
  endfunction

  initial for (int i = 0; i < D; i++) mem[i] <= 8'(i);

  always @(posedge clock) begin
    mem_data_out <= rd_word(mem_address);
    if (mem_read_write)
      for (int i = 0; i < 4; i++)
        if (i < (1 << mem_access_size)) mem[(mem_address - START + 32'(i)) % D] <= mem_data_in[8*i +: 8];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic drv0(input logic req, input logic rw, input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    m0_req = req; m0_rw = rw; m0_addr = a; m0_size = s; m0_wdata = w;
  endtask

  task automatic drv1(input logic req, input logic rw, input logic [31:0] a, input logic [1:0] s, input logic [31:0] w);
    m1_req = req; m1_rw = rw; m1_addr = a; m1_size = s; m1_wdata = w;
  endtask

  // called just after a negedge with inputs applied; returns at the following negedge
  task automatic tick(input string tag, input logic eg0, input logic eg1, input logic ewr);
    #1;
    chk({tag, ".gnt0"}, 32'(m0_gnt), 32'(eg0));
    chk({tag, ".gnt1"}, 32'(m1_gnt), 32'(eg1));
    chk({tag, ".wr"}, 32'(mem_read_write), 32'(ewr));
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic rsp(input string tag, input logic ev0, input logic ev1, input logic ee, input logic [31:0] ed);
    chk({tag, ".rv0"}, 32'(m0_rvalid), 32'(ev0));
    chk({tag, ".rv1"}, 32'(m1_rvalid), 32'(ev1));
    chk({tag, ".err0"}, 32'(m0_err), 32'(ev0 & ee));
    chk({tag, ".err1"}, 32'(m1_err), 32'(ev1 & ee));
    chk({tag, ".rd0"}, m0_rdata, ev0 ? ed : 32'h0);
    chk({tag, ".rd1"}, m1_rdata, ev1 ? ed : 32'h0);
  endtask

  initial begin
    reset_n = 1'b0;
    drv0(1, 0, START, 2, 0);
    drv1(0, 0, 0, 0, 0);
    repeat (2) begin
      @(posedge clock);
      #1;
      chk("rst.gnt0", 32'(m0_gnt), 0);
      chk("rst.rv0", 32'(m0_rvalid), 0);
      chk("rst.wr", 32'(mem_read_write), 0);
      chk("rst.addr", mem_address, 0);
      chk("rst.rdata", m0_rdata, 0);
    end
    @(negedge clock);
    reset_n = 1'b1;
    #1;
    chk("rel.gnt0", 32'(m0_gnt), 0);
    @(posedge clock);
    #1;
    chk("rel.rv0", 32'(m0_rvalid), 0);
    chk("rel.gnt0_after_edge", 32'(m0_gnt), 1);
    @(negedge clock);
    drv0(0, 0, START, 2, 0);
    @(posedge clock);
    @(negedge clock);
    chk("rel.rv0_dropped", 32'(m0_rvalid), 0);

    drv0(1, 1, START + 32'h4, 2, 32'hDEADBEEF);
    #1;
    chk("wr.addr", mem_address, START + 32'h4);
    chk("wr.din", mem_data_in, 32'hDEADBEEF);
    tick("wr", 1, 0, 1);
    rsp("wr", 0, 0, 0, 0);
    drv0(1, 0, START + 32'h4, 2, 0);
    tick("rd", 1, 0, 0);
    rsp("rd", 1, 0, 0, 32'hDEADBEEF);
    drv0(0, 0, 0, 0, 0);
    tick("idle", 0, 0, 0);
    rsp("idle", 0, 0, 0, 0);
    chk("idle.addr_hold", mem_address, START + 32'h4);

    drv1(1, 0, START + 32'h10, 2, 0);
    tick("m1rd", 0, 1, 0);
    rsp("m1rd", 0, 1, 0, 32'h13121110);

    drv0(1, 0, START, 2, 0);
    for (int i = 0; i < 9; i++) begin
`ifdef DMEM_ARB_RR_EN
      e0 = (i % 2 == 0);
`else
      e0 = (i < 8);
`endif
      tick($sformatf("cont%0d", i), e0, ~e0, 0);
      rsp($sformatf("cont%0d", i), e0, ~e0, 0, e0 ? 32'h03020100 : 32'h13121110);
    end
    drv0(0, 0, 0, 0, 0);

    drv1(1, 0, 32'h00FF_FFFC, 2, 0);
    tick("ill.low", 0, 1, 0);
    rsp("ill.low", 0, 1, 1, 0);
    drv1(1, 0, START, 3, 0);
    tick("ill.size", 0, 1, 0);
    rsp("ill.size", 0, 1, 1, 0);
    drv1(1, 1, START + 32'(D) - 32'd2, 2, 32'hFFFFFFFF);
    tick("ill.end", 0, 1, 0);
    rsp("ill.end", 0, 1, 1, 0);
    bexp = {8'(D - 1), 8'(D - 2), 8'(D - 3), 8'(D - 4)};
    drv1(1, 0, START + 32'(D) - 32'd4, 2, 0);
    tick("edge.rd", 0, 1, 0);
    rsp("edge.rd", 0, 1, 0, bexp);

    for (int i = 0; i < 6; i++) begin
      e0 = (i % 2 == 0);
      drv0(e0, 0, START, 2, 0);
      drv1(~e0, 0, START + 32'h10, 2, 0);
      tick($sformatf("il%0d", i), e0, ~e0, 0);
      rsp($sformatf("il%0d", i), e0, ~e0, 0, e0 ? 32'h03020100 : 32'h13121110);
    end

    drv0(0, 0, 0, 0, 0);
    drv1(1, 1, START + 32'h3, 0, 32'h000000A5);
    tick("bw", 0, 1, 1);
    rsp("bw", 0, 0, 0, 0);
    drv1(0, 0, 0, 0, 0);
    drv0(1, 0, START, 2, 0);
    tick("bw.rd", 1, 0, 0);
    rsp("bw.rd", 1, 0, 0, 32'hA5020100);
    chk("bw.top", 32'(m0_rdata[31:24]), 32'hA5);

    drv0(1, 0, START, 2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst.gnt0", 32'(m0_gnt), 0);
    @(posedge clock);
    #1;
    chk("midrst.rv0", 32'(m0_rvalid), 0);
    @(negedge clock);
    drv0(0, 0, 0, 0, 0);
    reset_n = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("midrst.rv0_after", 32'(m0_rvalid), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
